cic_d_stream_ctrl: RTL and testbench

- Sequencer for the CIC decimator in the ADC capture path.
- On start: pulses the decimator's reset, discards its start-up transient outputs, then buffers decimated samples in a small FIFO.
- Emits samples as AXI-Stream frames of programmable length with tlast.
- On stop: finishes the frame in progress, drains the FIFO and returns to idle; reports busy and a sticky overflow flag.

---
 rtl/cic_d_stream_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_cic_d_stream_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_d_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cic_d_stream_ctrl
//  Brief    : CIC decimator sequencer -- flushes and settles the decimator,
//             buffers its samples and emits AXI-Stream frames with tlast.
//  Revision : 1.0  initial release
// ============================================================================
module cic_d_stream_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int FRAME_LEN_W    = 16,
    parameter int FLUSH_CYCLES   = 4,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    output logic                   cic_reset_n,
    input  logic [DATA_WIDTH-1:0]  cic_data,
    input  logic                   cic_dv,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   overflow
);

    localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w    = c_ptr_w + 1;
    localparam int c_flush_w  = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam int c_settle_w = (SETTLE_SAMPLES < 1) ? 1 : $clog2(SETTLE_SAMPLES + 1);

    localparam logic [c_cnt_w-1:0]    c_depth       = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_flush_w-1:0]  c_flush_last  = c_flush_w'(FLUSH_CYCLES - 1);
    localparam logic [c_settle_w-1:0] c_settle_init = c_settle_w'(SETTLE_SAMPLES);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_flush  = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_run    = 3'd3;
    localparam logic [2:0] c_st_drain  = 3'd4;

    logic [2:0]             r_state;
    logic [c_flush_w-1:0]   r_flush_cnt;
    logic [c_settle_w-1:0]  r_settle_cnt;
    logic [FRAME_LEN_W-1:0] r_frame_len;
    logic [FRAME_LEN_W-1:0] r_push_cnt;
    logic                   r_stop_pending;
    logic                   r_overflow;
    logic                   r_cic_reset_n;

    logic [DATA_WIDTH:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic [DATA_WIDTH-1:0]  r_tdata;
    logic                   r_tlast;
    logic                   r_tvalid;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_last;
    logic [c_ptr_w-1:0]     w_rd_ptr_nxt;
    logic [c_cnt_w-1:0]     w_count_nxt;
    logic [DATA_WIDTH:0]    w_head;

    always_comb begin
        w_full   = (r_count == c_depth);
        w_pop    = r_tvalid & m_axis_tready;
        w_last   = (r_push_cnt == (r_frame_len - FRAME_LEN_W'(1)));
        // Once a stop is pending at a frame boundary, no new frame is opened.
        w_accept = (r_state == c_st_run) && !(r_stop_pending && (r_push_cnt == '0));
        w_push   = w_accept && cic_dv && (!w_full || w_pop);
        w_drop   = w_accept && cic_dv && w_full && !w_pop;

        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_ptr_w'(1)) : r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_cnt_w'(1);
        end

        // New head is the incoming word only when the buffer is otherwise empty.
        if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head = {w_last, cic_data};
        end else begin
            w_head = r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, cic_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_tvalid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_tdata <= w_head[DATA_WIDTH-1:0];
                r_tlast <= w_head[DATA_WIDTH];
            end else begin
                r_tlast <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= c_st_idle;
            r_flush_cnt    <= '0;
            r_settle_cnt   <= '0;
            r_frame_len    <= FRAME_LEN_W'(1);
            r_push_cnt     <= '0;
            r_stop_pending <= 1'b0;
            r_overflow     <= 1'b0;
            r_cic_reset_n  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cic_reset_n <= 1'b0;
                    if (start) begin
                        r_state        <= c_st_flush;
                        r_frame_len    <= (frame_len == '0) ? FRAME_LEN_W'(1) : frame_len;
                        r_overflow     <= 1'b0;
                        r_flush_cnt    <= '0;
                        r_push_cnt     <= '0;
                        r_stop_pending <= 1'b0;
                    end
                end

                c_st_flush: begin
                    if (stop) begin
                        r_state       <= c_st_idle;
                        r_cic_reset_n <= 1'b0;
                    end else if (r_flush_cnt == c_flush_last) begin
                        r_state       <= c_st_settle;
                        r_cic_reset_n <= 1'b1;
                        r_settle_cnt  <= c_settle_init;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_flush_w'(1);
                    end
                end

                c_st_settle: begin
                    if (stop) begin
                        r_state       <= c_st_idle;
                        r_cic_reset_n <= 1'b0;
                    end else if (r_settle_cnt == '0) begin
                        r_state <= c_st_run;
                    end else if (cic_dv) begin
                        r_settle_cnt <= r_settle_cnt - c_settle_w'(1);
                        if (r_settle_cnt == c_settle_w'(1)) begin
                            r_state <= c_st_run;
                        end
                    end
                end

                c_st_run: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_push) begin
                        r_push_cnt <= w_last ? '0 : (r_push_cnt + FRAME_LEN_W'(1));
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_stop_pending && ((r_push_cnt == '0) || (w_push && w_last))) begin
                        r_state <= c_st_drain;
                    end
                end

                c_st_drain: begin
                    if ((r_count == '0) && !r_tvalid) begin
                        r_state       <= c_st_idle;
                        r_cic_reset_n <= 1'b0;
                    end
                end

                default: begin
                    r_state       <= c_st_idle;
                    r_cic_reset_n <= 1'b0;
                end
            endcase
        end
    end

    assign cic_reset_n   = r_cic_reset_n;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != c_st_idle);
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cic_d_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_d_stream_ctrl
//  Brief    : Self-checking bench for cic_d_stream_ctrl (vector table plus
//             scoreboard on the AXI-Stream output).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cic_d_stream_ctrl;

    localparam int DATA_WIDTH     = 16;
    localparam int FIFO_DEPTH     = 16;
    localparam int FRAME_LEN_W    = 16;
    localparam int FLUSH_CYCLES   = 4;
    localparam int SETTLE_SAMPLES = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   start;
    logic                   stop;
    logic [FRAME_LEN_W-1:0] frame_len;
    logic                   cic_reset_n;
    logic [DATA_WIDTH-1:0]  cic_data;
    logic                   cic_dv;
    logic [DATA_WIDTH-1:0]  m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   m_axis_tlast;
    logic                   busy;
    logic                   overflow;

    cic_d_stream_ctrl #(
        .DATA_WIDTH     (DATA_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FRAME_LEN_W    (FRAME_LEN_W),
        .FLUSH_CYCLES   (FLUSH_CYCLES),
        .SETTLE_SAMPLES (SETTLE_SAMPLES)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .frame_len     (frame_len),
        .cic_reset_n   (cic_reset_n),
        .cic_data      (cic_data),
        .cic_dv        (cic_dv),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic        stop;
        logic        dv;
        logic [15:0] data;
        logic        acc;
        logic        crn;
        logic        busy;
        logic        tvalid;
    } vec_t;

    vec_t          vecs [18];
    logic [16:0]   sb [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            tb_cnt   = 0;
    int            tb_len   = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {last, data} goes into the scoreboard as the sample is driven.
    task automatic send_sample(input logic [15:0] d, input bit acc);
        logic last;
        cic_dv   = 1'b1;
        cic_data = d;
        if (acc) begin
            last = (tb_cnt == tb_len - 1);
            sb.push_back({last, d});
            tb_cnt = last ? 0 : tb_cnt + 1;
        end
        tick();
        cic_dv = 1'b0;
    endtask

    task automatic do_start(input int len);
        frame_len = FRAME_LEN_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        tb_cnt = 0;
        tb_len = (len == 0) ? 1 : len;
        repeat (FLUSH_CYCLES) tick();
        for (int i = 0; i < SETTLE_SAMPLES; i++) send_sample(16'hDEAD, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Output monitor: transfers are judged on the falling edge before the
    // rising edge that completes them; stalled words must not change.
    logic [15:0] held_data;
    logic        held_last;
    bit          held_v = 1'b0;
    always @(negedge clk) begin
        logic [16:0] e;
        if (!reset_n) begin
            held_v = 1'b0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            held_v = 1'b0;
            if (sb.size() == 0) begin
                check("unexpected_output", {15'd0, m_axis_tlast, m_axis_tdata}, 32'h1_FFFF);
            end else begin
                e = sb.pop_front();
                check("out_tdata", {16'd0, m_axis_tdata}, {16'd0, e[15:0]});
                check("out_tlast", {31'd0, m_axis_tlast}, {31'd0, e[16]});
            end
        end else if (m_axis_tvalid) begin
            if (held_v) begin
                check("stall_tdata", {16'd0, m_axis_tdata}, {16'd0, held_data});
                check("stall_tlast", {31'd0, m_axis_tlast}, {31'd0, held_last});
            end
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
            held_v    = 1'b1;
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; frame_len = '0;
        cic_data = '0; cic_dv = 1'b0; m_axis_tready = 1'b1;

        // Start-up sequence table: start, 4 flush cycles, 4 discarded, 8 kept.
        vecs[0] = '{start:1, stop:0, dv:0, data:16'd0, acc:0, crn:0, busy:1, tvalid:0};
        for (int i = 1; i <= 3; i++)
            vecs[i] = '{start:0, stop:0, dv:0, data:16'd0, acc:0, crn:0, busy:1, tvalid:0};
        vecs[4] = '{start:0, stop:0, dv:0, data:16'd0, acc:0, crn:1, busy:1, tvalid:0};
        for (int i = 5; i <= 8; i++)
            vecs[i] = '{start:0, stop:0, dv:1, data:16'(i - 4), acc:0, crn:1, busy:1, tvalid:0};
        for (int i = 9; i <= 16; i++)
            vecs[i] = '{start:0, stop:0, dv:1, data:16'(i - 4), acc:1, crn:1, busy:1, tvalid:1};
        vecs[17] = '{start:0, stop:0, dv:0, data:16'd0, acc:0, crn:1, busy:1, tvalid:0};

        repeat (3) tick();
        check("rst_cic_reset_n", {31'd0, cic_reset_n}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_tdata", {16'd0, m_axis_tdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic frame
        frame_len = 16'd4;
        tb_cnt = 0;
        tb_len = 4;
        for (int i = 0; i < 18; i++) begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
            if (vecs[i].dv) begin
                send_sample(vecs[i].data, vecs[i].acc);
            end else begin
                tick();
            end
            start = 1'b0;
            stop  = 1'b0;
            check($sformatf("vec%0d_cic_reset_n", i), {31'd0, cic_reset_n}, {31'd0, vecs[i].crn});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            check($sformatf("vec%0d_tvalid", i), {31'd0, m_axis_tvalid}, {31'd0, vecs[i].tvalid});
        end
        pulse_stop();
        wait_idle("basic_idle");
        check("basic_cic_reset_n", {31'd0, cic_reset_n}, 32'd0);

        // Backpressure and overflow
        m_axis_tready = 1'b0;
        do_start(4);
        for (int i = 0; i < 16; i++) send_sample(16'(100 + i), 1'b1);
        check("bp_no_overflow", {31'd0, overflow}, 32'd0);
        check("bp_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check("bp_head", {16'd0, m_axis_tdata}, 32'd100);
        send_sample(16'd999, 1'b0);
        check("bp_overflow", {31'd0, overflow}, 32'd1);
        m_axis_tready = 1'b1;
        for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
        check("bp_drained", sb.size(), 32'd0);
        pulse_stop();
        wait_idle("bp_idle");
        check("bp_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Stop mid-frame
        do_start(8);
        check("sm_overflow_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 3; i++) send_sample(16'(200 + i), 1'b1);
        pulse_stop();
        for (int i = 3; i < 8; i++) send_sample(16'(200 + i), 1'b1);
        wait_idle("sm_idle");
        check("sm_cic_reset_n", {31'd0, cic_reset_n}, 32'd0);
        send_sample(16'd300, 1'b0);
        send_sample(16'd301, 1'b0);
        check("sm_ignored_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("sm_ignored_busy", {31'd0, busy}, 32'd0);

        // Stop during SETTLE, then frame_len=0
        frame_len = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FLUSH_CYCLES) tick();
        send_sample(16'd1, 1'b0);
        send_sample(16'd2, 1'b0);
        pulse_stop();
        check("ss_busy", {31'd0, busy}, 32'd0);
        check("ss_cic_reset_n", {31'd0, cic_reset_n}, 32'd0);
        check("ss_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        do_start(0);
        for (int i = 0; i < 3; i++) send_sample(16'(400 + i), 1'b1);
        pulse_stop();
        wait_idle("fl0_idle");

        // Reset mid-RUN with 5 samples buffered
        m_axis_tready = 1'b0;
        do_start(8);
        for (int i = 0; i < 5; i++) send_sample(16'(500 + i), 1'b0);
        check("mr_tvalid_before", {31'd0, m_axis_tvalid}, 32'd1);
        reset_n = 1'b0;
        tick();
        check("mr_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("mr_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_overflow", {31'd0, overflow}, 32'd0);
        check("mr_cic_reset_n", {31'd0, cic_reset_n}, 32'd0);
        reset_n = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        do_start(4);
        for (int i = 0; i < 4; i++) send_sample(16'(600 + i), 1'b1);
        pulse_stop();
        wait_idle("mr_restart_idle");

        // start+stop in IDLE accepted; start while busy ignored
        frame_len = 16'd4;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_idle_busy", {31'd0, busy}, 32'd1);
        frame_len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bs_flush1", {31'd0, cic_reset_n}, 32'd0);
        tick();
        check("bs_flush2", {31'd0, cic_reset_n}, 32'd0);
        tick();
        check("bs_flush3", {31'd0, cic_reset_n}, 32'd0);
        tick();
        check("bs_settle", {31'd0, cic_reset_n}, 32'd1);
        for (int i = 0; i < SETTLE_SAMPLES; i++) send_sample(16'hBEEF, 1'b0);
        tb_cnt = 0;
        tb_len = 4;
        start = 1'b1;
        send_sample(16'd700, 1'b1);
        start = 1'b0;
        for (int i = 1; i < 4; i++) send_sample(16'(700 + i), 1'b1);
        pulse_stop();
        wait_idle("bs_idle");

        repeat (3) tick();
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
